// File: rtl/life_grid.sv
// ROWS x COLS Life-style cellular automaton that advances every cell one generation per step.
// It supports pause, single-step and bulk load, and can halt itself once the pattern stops changing.
module life_grid #(
    parameter int unsigned ROWS           = 8,
    parameter int unsigned COLS           = 8,
    parameter int unsigned WRAP           = 1,
    parameter logic [8:0]  BIRTH_MASK     = 9'b000001000,
    parameter logic [8:0]  SURVIVE_MASK   = 9'b000001100,
    parameter int unsigned GEN_W          = 16,
    parameter int unsigned HALT_ON_STABLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_en,
    input  logic                 pause,
    input  logic                 single_step,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] load_data,
    output logic [ROWS*COLS-1:0] grid_out,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 extinct,
    output logic                 halted
);
    localparam int NR = int'(ROWS);
    localparam int NC = int'(COLS);

    typedef enum logic [1:0] {StRun, StPause, StHalt} state_t;

    state_t                state_q, state_d;
    logic [ROWS*COLS-1:0]  grid_q, grid_d, next_gen;
    logic [GEN_W-1:0]      gen_q, gen_d;
    logic                  stable_q, stable_d;
    logic                  extinct_q, extinct_d;
    logic                  do_step;

    // Next state of cell (r,c). With WRAP=0, neighbours that fall off the grid count as dead.
    function automatic logic cell_next(input logic [ROWS*COLS-1:0] g, input int r, input int c);
        logic [3:0] n;
        int rr;
        int cc;
        n = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (WRAP != 0) begin
                    rr = (rr + NR) % NR;
                    cc = (cc + NC) % NC;
                end
                if (!(dr == 0 && dc == 0) && rr >= 0 && rr < NR && cc >= 0 && cc < NC) begin
                    n = n + 4'(g[rr*NC + cc]);
                end
            end
        end
        return g[r*NC + c] ? SURVIVE_MASK[n] : BIRTH_MASK[n];
    endfunction

    always_comb begin
        next_gen = '0;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                next_gen[r*NC + c] = cell_next(grid_q, r, c);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        gen_d     = gen_q;
        stable_d  = stable_q;
        extinct_d = extinct_q;
        do_step   = 1'b0;
        if (load) begin
            grid_d    = load_data;
            gen_d     = '0;
            stable_d  = 1'b0;
            extinct_d = (load_data == '0);
            state_d   = pause ? StPause : StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (pause) state_d = StPause;
                    else       do_step = step_en;
                end
                StPause: begin
                    if (!pause) state_d = StRun;
                    else        do_step = single_step;
                end
                StHalt:  ;
                default: state_d = StRun;
            endcase
            if (do_step) begin
                grid_d    = next_gen;
                if (gen_q != '1) gen_d = gen_q + 1'b1;
                stable_d  = (next_gen == grid_q);
                extinct_d = (next_gen == '0);
                if (HALT_ON_STABLE != 0 && next_gen == grid_q) state_d = StHalt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StRun;
            grid_q    <= '0;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            gen_q     <= gen_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
        end
    end

    assign grid_out  = grid_q;
    assign gen_count = gen_q;
    assign stable    = stable_q;
    assign extinct   = extinct_q;
    assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_life_grid.sv
// Scoreboard bench for life_grid: four instances in different configurations share the step strobes.
// Each test loads its own instance first, so activity on the other instances does not matter.
module tb_life_grid;
    logic        clk = 1'b0;
    logic        reset, step_en, pause, single_step;
    logic        load_a, load_b, load_c, load_d;
    logic [63:0] ld;

    logic [63:0] grid_a, grid_c, grid_d;
    logic [24:0] grid_b;
    logic [15:0] gen_a, gen_b, gen_c;
    logic [1:0]  gen_d;
    logic        st_a, ex_a, ha_a, st_b, ex_b, ha_b, st_c, ex_c, ha_c, st_d, ex_d, ha_d;

    always #5 clk = ~clk;

    // a: 8x8 torus, b: 5x5 bounded, c: 8x8 bounded, d: 8x8 torus with a 2-bit counter
    life_grid #(.ROWS(8), .COLS(8), .WRAP(1)) dut_a (
        .clk(clk), .reset(reset), .step_en(step_en), .pause(pause), .single_step(single_step),
        .load(load_a), .load_data(ld), .grid_out(grid_a), .gen_count(gen_a),
        .stable(st_a), .extinct(ex_a), .halted(ha_a));
    life_grid #(.ROWS(5), .COLS(5), .WRAP(0)) dut_b (
        .clk(clk), .reset(reset), .step_en(step_en), .pause(pause), .single_step(single_step),
        .load(load_b), .load_data(ld[24:0]), .grid_out(grid_b), .gen_count(gen_b),
        .stable(st_b), .extinct(ex_b), .halted(ha_b));
    life_grid #(.ROWS(8), .COLS(8), .WRAP(0)) dut_c (
        .clk(clk), .reset(reset), .step_en(step_en), .pause(pause), .single_step(single_step),
        .load(load_c), .load_data(ld), .grid_out(grid_c), .gen_count(gen_c),
        .stable(st_c), .extinct(ex_c), .halted(ha_c));
    life_grid #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(2)) dut_d (
        .clk(clk), .reset(reset), .step_en(step_en), .pause(pause), .single_step(single_step),
        .load(load_d), .load_data(ld), .grid_out(grid_d), .gen_count(gen_d),
        .stable(st_d), .extinct(ex_d), .halted(ha_d));

    typedef struct {
        int          id;
        string       name;
        logic [63:0] grid;
        logic [15:0] gen;
        logic [2:0]  flags;   // {stable, extinct, halted}
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] obs_grid [4];
    logic [15:0] obs_gen  [4];
    logic [2:0]  obs_flags[4];

    assign obs_grid[0]  = grid_a;
    assign obs_grid[1]  = {39'd0, grid_b};
    assign obs_grid[2]  = grid_c;
    assign obs_grid[3]  = grid_d;
    assign obs_gen[0]   = gen_a;
    assign obs_gen[1]   = gen_b;
    assign obs_gen[2]   = gen_c;
    assign obs_gen[3]   = {14'd0, gen_d};
    assign obs_flags[0] = {st_a, ex_a, ha_a};
    assign obs_flags[1] = {st_b, ex_b, ha_b};
    assign obs_flags[2] = {st_c, ex_c, ha_c};
    assign obs_flags[3] = {st_d, ex_d, ha_d};

    // Monitor: drains every pending expectation half a cycle after the edge it refers to.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs_grid[e.id] !== e.grid || obs_gen[e.id] !== e.gen
                || obs_flags[e.id] !== e.flags) begin
                errors++;
                $display("FAIL %s: got grid=%h gen=%0d sxh=%b, want grid=%h gen=%0d sxh=%b",
                         e.name, obs_grid[e.id], obs_gen[e.id], obs_flags[e.id],
                         e.grid, e.gen, e.flags);
            end
        end
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [63:0] mk(input int c0 = -1, input int c1 = -1, input int c2 = -1,
                                       input int c3 = -1, input int c4 = -1);
        logic [63:0] g;
        int          cs[5];
        g  = '0;
        cs = '{c0, c1, c2, c3, c4};
        foreach (cs[i]) if (cs[i] >= 0) g[cs[i]] = 1'b1;
        return g;
    endfunction

    task automatic expect_out(input int id, input string name, input logic [63:0] grid,
                              input int gen, input logic st, input logic ex, input logic ha);
        exp_t x;
        x.id    = id;
        x.name  = name;
        x.grid  = grid;
        x.gen   = 16'(gen);
        x.flags = {st, ex, ha};
        sb.push_back(x);
    endtask

    // Immediate comparison of every instance against the reset state.
    task automatic check_reset_now(input string name);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_grid[i] !== '0 || obs_gen[i] !== '0 || obs_flags[i] !== 3'b010) begin
                errors++;
                $display("FAIL %s[%0d]: got grid=%h gen=%0d sxh=%b, want reset state",
                         name, i, obs_grid[i], obs_gen[i], obs_flags[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int id, input logic [63:0] data, input logic p);
        ld     = data;
        pause  = p;
        load_a = (id == 0);
        load_b = (id == 1);
        load_c = (id == 2);
        load_d = (id == 3);
        tick();
        {load_a, load_b, load_c, load_d} = '0;
    endtask

    // Holds step_en high for n consecutive cycles.
    task automatic steps(input int n);
        step_en = 1'b1;
        repeat (n) tick();
        step_en = 1'b0;
    endtask

    logic [63:0] glider, block;
    int          wait_cnt;

    initial begin
        glider = mk(1, 10, 16, 17, 18);
        block  = mk(27, 28, 35, 36);
        reset = 1'b1; step_en = 1'b0; pause = 1'b0; single_step = 1'b0; ld = '0;
        {load_a, load_b, load_c, load_d} = '0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_now("reset_direct");
        expect_out(0, "reset_a", '0, 0, 0, 1, 0);
        expect_out(3, "reset_d", '0, 0, 0, 1, 0);
        tick();

        // 5x5 bounded blinker
        do_load(1, mk(7, 12, 17), 1'b0);
        expect_out(1, "blinker_load", mk(7, 12, 17), 0, 0, 0, 0);
        steps(1);
        expect_out(1, "blinker_gen1", mk(11, 12, 13), 1, 0, 0, 0);
        steps(1);
        expect_out(1, "blinker_gen2", mk(7, 12, 17), 2, 0, 0, 0);

        // glider on the 8x8 torus comes home after 32 generations
        do_load(0, glider, 1'b0);
        steps(4);
        expect_out(0, "glider_gen4", mk(10, 19, 25, 26, 27), 4, 0, 0, 0);
        steps(28);
        expect_out(0, "glider_gen32", glider, 32, 0, 0, 0);

        // still life halts; further strobes ignored until a load
        do_load(0, block, 1'b0);
        steps(1);
        expect_out(0, "block_halt", block, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            steps(1);
            tick();
        end
        pause = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            single_step = 1'b1;
            tick();
            single_step = 1'b0;
            tick();
        end
        pause = 1'b0;
        tick();
        expect_out(0, "halt_holds", block, 1, 1, 0, 1);
        do_load(0, glider, 1'b0);
        expect_out(0, "halt_reload", glider, 0, 0, 0, 0);

        // corner cells with and without wrap
        ld = mk(0, 1, 7);
        load_a = 1'b1;
        load_c = 1'b1;
        tick();
        load_a = 1'b0;
        load_c = 1'b0;
        steps(1);
        expect_out(0, "edge_wrap", mk(0, 8, 56), 1, 0, 0, 0);
        expect_out(2, "edge_nowrap", '0, 1, 0, 1, 0);

        // pause: step_en ignored, single_step advances
        do_load(0, glider, 1'b1);
        for (int i = 0; i < 5; i++) begin
            steps(1);
            tick();
        end
        expect_out(0, "pause_ignores_step", glider, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            single_step = 1'b1;
            tick();
            single_step = 1'b0;
            tick();
        end
        expect_out(0, "pause_single2", mk(10, 16, 18, 25, 26), 2, 0, 0, 0);
        pause = 1'b0;
        tick();
        steps(1);
        expect_out(0, "resume_run", mk(9, 18, 19, 25, 26), 3, 0, 0, 0);

        // 2-bit counter saturation, then reset beats a coincident step
        do_load(3, mk(17, 18, 19), 1'b0);
        steps(5);
        expect_out(3, "gen_saturate", mk(10, 18, 26), 3, 0, 0, 0);
        step_en = 1'b1;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        step_en = 1'b0;
        check_reset_now("reset_mid_direct");
        expect_out(3, "reset_mid_d", '0, 0, 0, 1, 0);
        expect_out(0, "reset_mid_a", '0, 0, 0, 1, 0);
        steps(1);
        expect_out(3, "post_reset_run", '0, 1, 1, 1, 1);
        tick();
        tick();

        // Bounded wait for the scoreboard to drain.
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            tick();
            wait_cnt++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expectations never checked", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_grid.md
Name: life_grid

Overview:
Parametrised ROWS x COLS cellular-automaton grid: the array-level successor to the per-LED on/off cell FSM. It holds every cell state in registers and advances all cells one generation per accepted step strobe, using a configurable birth/survive rule and optional toroidal wrap. It supports pause, single-step, bulk load, a generation counter and stable/extinct detection with optional auto-halt. It sits between the tick generator/key debouncers and the LED-matrix driver.

Parameters:
ROWS, 8, grid rows (>=3)
COLS, 8, grid columns (>=3)
WRAP, 1, 1 = toroidal neighbours; 0 = off-grid neighbours read as dead
BIRTH_MASK, 9'b000001000, bit k=1: dead cell with k live neighbours becomes live (B3)
SURVIVE_MASK, 9'b000001100, bit k=1: live cell with k live neighbours stays live (S23)
GEN_W, 16, generation counter width
HALT_ON_STABLE, 1, 1 = enter HALT when a step produces no change

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
step_en  input  1  one-cycle generation tick (used in RUN)
pause  input  1  level; 1 holds the grid in PAUSE
single_step  input  1  one-cycle pulse; advances one generation in PAUSE only
load  input  1  one-cycle pulse; bulk-load grid
load_data  input  ROWS*COLS  seed pattern, bit r*COLS+c = cell (r,c)
grid_out  output  ROWS*COLS  current cell states, same indexing
gen_count  output  GEN_W  generations since reset/load, saturating
stable  output  1  last executed step produced no change
extinct  output  1  all cells dead
halted  output  1  FSM in HALT

Behaviour:
- Reset (synchronous, dominant over all inputs): grid_out=0, gen_count=0, stable=0, extinct=1, halted=0, FSM=RUN.
- FSM states RUN, PAUSE, HALT. Input priority per cycle: reset > load > pause > step.
- load=1 (any state): grid_out<=load_data, gen_count<=0, stable<=0, extinct<=(load_data==0); next state PAUSE if pause=1 else RUN. Any coincident step is discarded.
- RUN: pause=1 -> PAUSE (no step that cycle). Otherwise step_en=1 executes a step.
- PAUSE: pause=0 -> RUN. While pause=1: step_en ignored; single_step=1 executes exactly one step.
- HALT: step_en, single_step and pause ignored; leave only via load or reset. halted=1 iff state==HALT.
- Step: for every cell, n = number of live cells among 8 neighbours (0..8, 4-bit). WRAP=1: row/col indices mod ROWS/COLS. WRAP=0: out-of-range neighbours = 0. next = cur ? SURVIVE_MASK[n] : BIRTH_MASK[n]. All cells update simultaneously on the same clk edge, computed from pre-edge values only; the result is visible on grid_out the cycle after the strobe (latency 1).
- On each step: gen_count<=gen_count+1, saturating at 2^GEN_W-1; stable<=(next==current); extinct<=(next==0). If HALT_ON_STABLE=1 and next==current, state<=HALT in the same edge.
- stable/extinct hold their values between steps; only a step, load or reset changes them.
- Strobes held high multiple cycles execute one step per cycle.

Test Plan:
- 5x5, WRAP=0, load vertical blinker at (1,2),(2,2),(3,2); step_en once -> grid_out = (2,1),(2,2),(2,3); second step -> original pattern; gen_count=2, stable=0.
- 8x8, WRAP=1, load glider; 32 step_en pulses -> grid_out equals seed, gen_count=32, extinct=0, halted=0.
- Load 2x2 block at (3,3); one step -> stable=1, halted=1; further step_en/single_step pulses -> grid and gen_count=1 unchanged; load new seed -> halted=0, gen_count=0.
- Edge wrap: live cells at (0,0),(0,1),(0,COLS-1) with WRAP=1 -> (ROWS-1,0) born after one step; same seed with WRAP=0 -> (ROWS-1,0) stays dead.
- pause=1 plus 5 step_en pulses -> no change; 2 single_step pulses -> gen_count+2; pause=0 -> RUN resumes on next step_en.
- GEN_W=2, blinker, 5 steps -> gen_count sticks at 3; reset asserted mid-run coincident with step_en -> grid 0, gen_count 0, extinct 1, FSM RUN.
